// File: rtl/commit_trace_buffer.sv
// Commit trace buffer: records recent (PC, instruction, sequence) commits in a circular
// buffer with wrap/stop modes and a PC trigger, then drains the frozen trace via valid/ready.
module commit_trace_buffer #(
    parameter int DEPTH       = 16,
    parameter int ADDR_WIDTH  = 32,
    parameter int INSTR_WIDTH = 32,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       commit_valid_i,
    input  logic [ADDR_WIDTH-1:0]      commit_pc_i,
    input  logic [INSTR_WIDTH-1:0]     commit_instr_i,
    input  logic                       arm_i,
    input  logic                       mode_i,
    input  logic                       trig_en_i,
    input  logic [ADDR_WIDTH-1:0]      trig_pc_i,
    input  logic [$clog2(DEPTH):0]     post_trig_i,
    input  logic                       rd_ready_i,
    output logic                       rd_valid_o,
    output logic [ADDR_WIDTH-1:0]      rd_pc_o,
    output logic [INSTR_WIDTH-1:0]     rd_instr_o,
    output logic [CNT_WIDTH-1:0]       rd_seq_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic [CNT_WIDTH-1:0]       commit_cnt_o,
    output logic                       overflow_o,
    output logic [1:0]                 state_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CW    = PTR_W + 1;
    localparam logic [PTR_W-1:0]     PTR_ONE  = PTR_W'(1);
    localparam logic [CW-1:0]        CNT_ONE  = CW'(1);
    localparam logic [CW-1:0]        FULL_CNT = CW'(DEPTH);
    localparam logic [CNT_WIDTH-1:0] SEQ_ONE  = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] SEQ_MAX  = {CNT_WIDTH{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RECORD = 2'd1,
        ST_POST   = 2'd2,
        ST_FROZEN = 2'd3
    } state_t;

    state_t                 state_r, state_s;
    logic [PTR_W-1:0]       wr_ptr_r, wr_ptr_s, rd_ptr_r, rd_ptr_s;
    logic [CW-1:0]          count_r, count_s, remaining_r, remaining_s;
    logic [CNT_WIDTH-1:0]   commit_cnt_r, commit_cnt_s;
    logic                   overflow_r, overflow_s;
    logic                   store_s, full_s, rd_valid_s, pop_s;

    logic [ADDR_WIDTH-1:0]  pc_mem_r    [DEPTH];
    logic [INSTR_WIDTH-1:0] instr_mem_r [DEPTH];
    logic [CNT_WIDTH-1:0]   seq_mem_r   [DEPTH];

    assign full_s     = (count_r == FULL_CNT);
    assign rd_valid_s = (state_r == ST_FROZEN) && (count_r != {CW{1'b0}});
    assign pop_s      = rd_valid_s && rd_ready_i && !arm_i;

    // Next-state and datapath control; arm overrides any commit or pop in the same cycle.
    always_comb begin
        state_s      = state_r;
        wr_ptr_s     = wr_ptr_r;
        rd_ptr_s     = rd_ptr_r;
        count_s      = count_r;
        remaining_s  = remaining_r;
        commit_cnt_s = commit_cnt_r;
        overflow_s   = overflow_r;
        store_s      = 1'b0;
        if (arm_i) begin
            state_s      = ST_RECORD;
            wr_ptr_s     = {PTR_W{1'b0}};
            rd_ptr_s     = {PTR_W{1'b0}};
            count_s      = {CW{1'b0}};
            remaining_s  = {CW{1'b0}};
            commit_cnt_s = {CNT_WIDTH{1'b0}};
            overflow_s   = 1'b0;
        end else begin
            case (state_r)
                ST_RECORD, ST_POST: begin
                    if (!commit_valid_i) begin
                        state_s = state_r;
                    end else if (mode_i && full_s) begin
                        // Only reachable if mode flipped to stop while already full.
                        overflow_s = 1'b1;
                        state_s    = ST_FROZEN;
                    end else begin
                        store_s      = 1'b1;
                        wr_ptr_s     = wr_ptr_r + PTR_ONE;
                        commit_cnt_s = (commit_cnt_r == SEQ_MAX) ? commit_cnt_r : commit_cnt_r + SEQ_ONE;
                        if (full_s) begin
                            rd_ptr_s   = rd_ptr_r + PTR_ONE;
                            overflow_s = 1'b1;
                        end else begin
                            count_s = count_r + CNT_ONE;
                        end
                        if (mode_i && (count_r == FULL_CNT - CNT_ONE)) begin
                            state_s = ST_FROZEN;
                        end else if (state_r == ST_RECORD) begin
                            if (trig_en_i && (commit_pc_i == trig_pc_i)) begin
                                if (post_trig_i == {CW{1'b0}}) begin
                                    state_s = ST_FROZEN;
                                end else begin
                                    remaining_s = post_trig_i;
                                    state_s     = ST_POST;
                                end
                            end else begin
                                state_s = ST_RECORD;
                            end
                        end else begin
                            remaining_s = remaining_r - CNT_ONE;
                            if (remaining_r == CNT_ONE) begin
                                state_s = ST_FROZEN;
                            end else begin
                                state_s = ST_POST;
                            end
                        end
                    end
                end
                ST_FROZEN: begin
                    if (commit_valid_i) begin
                        overflow_s = 1'b1;
                    end else begin
                        overflow_s = overflow_r;
                    end
                    if (pop_s) begin
                        rd_ptr_s = rd_ptr_r + PTR_ONE;
                        count_s  = count_r - CNT_ONE;
                    end else begin
                        rd_ptr_s = rd_ptr_r;
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                end
            endcase
        end
    end

    // Control and status registers.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_r      <= ST_IDLE;
            wr_ptr_r     <= {PTR_W{1'b0}};
            rd_ptr_r     <= {PTR_W{1'b0}};
            count_r      <= {CW{1'b0}};
            remaining_r  <= {CW{1'b0}};
            commit_cnt_r <= {CNT_WIDTH{1'b0}};
            overflow_r   <= 1'b0;
        end else begin
            state_r      <= state_s;
            wr_ptr_r     <= wr_ptr_s;
            rd_ptr_r     <= rd_ptr_s;
            count_r      <= count_s;
            remaining_r  <= remaining_s;
            commit_cnt_r <= commit_cnt_s;
            overflow_r   <= overflow_s;
        end
    end

    // Trace storage; contents are don't-care after reset so no reset is applied.
    always_ff @(posedge clk_i) begin
        if (store_s) begin
            pc_mem_r[wr_ptr_r]    <= commit_pc_i;
            instr_mem_r[wr_ptr_r] <= commit_instr_i;
            seq_mem_r[wr_ptr_r]   <= commit_cnt_r;
        end
    end

    assign rd_valid_o   = rd_valid_s;
    assign rd_pc_o      = pc_mem_r[rd_ptr_r];
    assign rd_instr_o   = instr_mem_r[rd_ptr_r];
    assign rd_seq_o     = seq_mem_r[rd_ptr_r];
    assign count_o      = count_r;
    assign commit_cnt_o = commit_cnt_r;
    assign overflow_o   = overflow_r;
    assign state_o      = state_r;
endmodule

// File: tb/tb_commit_trace_buffer.sv
// Directed bench for commit_trace_buffer at DEPTH=4: reset, wrap/stop modes, post-trigger,
// backpressure with re-arm, and asynchronous reset mid-POST.
module tb_commit_trace_buffer;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        commit_valid = 1'b0;
    logic [31:0] commit_pc = 32'd0;
    logic [31:0] commit_instr = 32'd0;
    logic        arm = 1'b0;
    logic        mode = 1'b0;
    logic        trig_en = 1'b0;
    logic [31:0] trig_pc = 32'd0;
    logic [2:0]  post_trig = 3'd0;
    logic        rd_ready = 1'b0;
    logic        rd_valid;
    logic [31:0] rd_pc, rd_instr, rd_seq, commit_cnt;
    logic [2:0]  count;
    logic        overflow;
    logic [1:0]  state;
    int          errors = 0;
    int          checks = 0;

    commit_trace_buffer #(.DEPTH(4), .ADDR_WIDTH(32), .INSTR_WIDTH(32), .CNT_WIDTH(32)) dut (
        .clk_i(clk), .rst_i(rst), .commit_valid_i(commit_valid), .commit_pc_i(commit_pc),
        .commit_instr_i(commit_instr), .arm_i(arm), .mode_i(mode), .trig_en_i(trig_en),
        .trig_pc_i(trig_pc), .post_trig_i(post_trig), .rd_ready_i(rd_ready),
        .rd_valid_o(rd_valid), .rd_pc_o(rd_pc), .rd_instr_o(rd_instr), .rd_seq_o(rd_seq),
        .count_o(count), .commit_cnt_o(commit_cnt), .overflow_o(overflow), .state_o(state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic commit(input logic [31:0] pc);
        commit_valid = 1'b1;
        commit_pc    = pc;
        commit_instr = pc ^ 32'hA5A5_0000;
        tick();
        commit_valid = 1'b0;
    endtask

    task automatic do_arm();
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    task automatic pop_chk(input string tag, input logic [31:0] pc, input logic [31:0] seq);
        chk({tag, "_valid"}, 64'(rd_valid), 64'd1);
        chk({tag, "_pc"}, 64'(rd_pc), 64'(pc));
        chk({tag, "_instr"}, 64'(rd_instr), 64'(pc ^ 32'hA5A5_0000));
        chk({tag, "_seq"}, 64'(rd_seq), 64'(seq));
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
    endtask

    task automatic status_chk(input string tag, input logic [1:0] st, input logic [2:0] cnt,
                              input logic [31:0] ccnt, input logic ovf);
        chk({tag, "_state"}, 64'(state), 64'(st));
        chk({tag, "_count"}, 64'(count), 64'(cnt));
        chk({tag, "_commit_cnt"}, 64'(commit_cnt), 64'(ccnt));
        chk({tag, "_overflow"}, 64'(overflow), 64'(ovf));
    endtask

    initial begin
        // 1. reset and IDLE
        repeat (2) @(posedge clk);
        #1;
        status_chk("rst", 2'd0, 3'd0, 32'd0, 1'b0);
        chk("rst_valid", 64'(rd_valid), 64'd0);
        rst = 1'b1;
        tick();
        for (int i = 1; i <= 3; i++) commit(32'(i));
        status_chk("idle", 2'd0, 3'd0, 32'd0, 1'b0);
        chk("idle_valid", 64'(rd_valid), 64'd0);

        // 2. wrap + trigger, no post
        mode = 1'b0; trig_en = 1'b1; trig_pc = 32'd6; post_trig = 3'd0;
        do_arm();
        chk("t2_armed", 64'(state), 64'd1);
        for (int i = 1; i <= 6; i++) commit(32'(i));
        status_chk("t2", 2'd3, 3'd4, 32'd6, 1'b1);
        for (int i = 0; i < 4; i++) pop_chk("t2_rd", 32'(i + 3), 32'(i + 2));
        chk("t2_empty_valid", 64'(rd_valid), 64'd0);
        status_chk("t2_empty", 2'd3, 3'd0, 32'd6, 1'b1);

        // 3. stop when full
        mode = 1'b1; trig_en = 1'b0;
        do_arm();
        status_chk("t3_armed", 2'd1, 3'd0, 32'd0, 1'b0);
        for (int i = 1; i <= 4; i++) commit(32'(i));
        status_chk("t3_full", 2'd3, 3'd4, 32'd4, 1'b0);
        commit(32'd5);
        commit(32'd6);
        status_chk("t3", 2'd3, 3'd4, 32'd4, 1'b1);
        for (int i = 0; i < 4; i++) pop_chk("t3_rd", 32'(i + 1), 32'(i));

        // 4. post-trigger
        mode = 1'b0; trig_en = 1'b1; trig_pc = 32'd8; post_trig = 3'd2;
        do_arm();
        for (int i = 5; i <= 8; i++) commit(32'(i));
        status_chk("t4_post", 2'd2, 3'd4, 32'd4, 1'b0);
        commit(32'd9);
        chk("t4_post2", 64'(state), 64'd2);
        commit(32'd10);
        status_chk("t4_frozen", 2'd3, 3'd4, 32'd6, 1'b1);
        commit(32'd11);
        status_chk("t4_drop", 2'd3, 3'd4, 32'd6, 1'b1);
        for (int i = 0; i < 4; i++) pop_chk("t4_rd", 32'(i + 7), 32'(i + 2));

        // 5. backpressure and re-arm
        mode = 1'b1; trig_en = 1'b0;
        do_arm();
        for (int i = 0; i < 4; i++) commit(32'h20 + 32'(i));
        chk("t5_front", 64'(rd_pc), 64'h20);
        rd_ready = 1'b1; tick();
        chk("t5_pop1_pc", 64'(rd_pc), 64'h21);
        chk("t5_pop1_cnt", 64'(count), 64'd3);
        rd_ready = 1'b0; tick();
        chk("t5_hold_pc", 64'(rd_pc), 64'h21);
        chk("t5_hold_seq", 64'(rd_seq), 64'd1);
        chk("t5_hold_cnt", 64'(count), 64'd3);
        rd_ready = 1'b1; tick();
        chk("t5_pop2_pc", 64'(rd_pc), 64'h22);
        chk("t5_pop2_cnt", 64'(count), 64'd2);
        arm = 1'b1; commit_valid = 1'b1; commit_pc = 32'h99;
        tick();
        arm = 1'b0; commit_valid = 1'b0; rd_ready = 1'b0;
        status_chk("t5_rearm", 2'd1, 3'd0, 32'd0, 1'b0);
        chk("t5_rearm_valid", 64'(rd_valid), 64'd0);

        // 6. reset mid-POST
        mode = 1'b0; trig_en = 1'b1; trig_pc = 32'd2; post_trig = 3'd2;
        do_arm();
        commit(32'd1);
        commit(32'd2);
        commit(32'd3);
        status_chk("t6_post", 2'd2, 3'd3, 32'd3, 1'b0);
        #2 rst = 1'b0;
        #1;
        status_chk("t6_rst", 2'd0, 3'd0, 32'd0, 1'b0);
        chk("t6_rst_valid", 64'(rd_valid), 64'd0);
        tick();
        rst = 1'b1;
        trig_pc = 32'h50; post_trig = 3'd0;
        do_arm();
        commit(32'h50);
        status_chk("t6_rec", 2'd3, 3'd1, 32'd1, 1'b0);
        pop_chk("t6_rd", 32'h50, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/commit_trace_buffer.md
# commit_trace_buffer

- Synthesizable hardware commit monitor. It sits on the CPU debug commit port: `debug_instr_is_completed_o`, `debug_pc_o` and `debug_instr_o`.
- Records the most recent committed (PC, instruction, sequence number) tuples into a circular buffer of parametrised depth.
- Supports wrap and stop-when-full modes, plus a PC-match trigger with a programmable post-trigger count.
- The frozen trace is drained through a valid/ready read port. This is the in-silicon successor of the bench commit checker.

## Interface

Parameters:
- `DEPTH`, 16, number of entries; power of two, ≥2.
- `ADDR_WIDTH`, 32, PC width.
- `INSTR_WIDTH`, 32, instruction width.
- `CNT_WIDTH`, 32, sequence/commit counter width.

Ports:
- `clk_i`  in  1  clock; all logic is on the rising edge.
- `rst_i`  in  1  reset, asynchronous, active-low.
- `commit_valid_i`  in  1  one instruction committed this cycle.
- `commit_pc_i`  in  ADDR_WIDTH  PC of the committed instruction.
- `commit_instr_i`  in  INSTR_WIDTH  committed instruction word.
- `arm_i`  in  1  pulse: clear the buffer and counters, enter RECORD.
- `mode_i`  in  1  0 = wrap (overwrite oldest), 1 = stop when full.
- `trig_en_i`  in  1  enable PC-match trigger.
- `trig_pc_i`  in  ADDR_WIDTH  trigger PC.
- `post_trig_i`  in  $clog2(DEPTH)+1  commits to record after the trigger commit.
- `rd_ready_i`  in  1  consumer accepts the read entry.
- `rd_valid_o`  out  1  read entry available.
- `rd_pc_o`  out  ADDR_WIDTH  oldest entry PC.
- `rd_instr_o`  out  INSTR_WIDTH  oldest entry instruction.
- `rd_seq_o`  out  CNT_WIDTH  oldest entry sequence number.
- `count_o`  out  $clog2(DEPTH)+1  entries stored.
- `commit_cnt_o`  out  CNT_WIDTH  commits seen in RECORD/POST since arm; saturates at all-ones.
- `overflow_o`  out  1  sticky: at least one commit was lost since arm.
- `state_o`  out  2  IDLE=0, RECORD=1, POST=2, FROZEN=3.

## Operation

**States**
- **IDLE:** commits are ignored.
- **Any state, `arm_i`=1:** go to RECORD. Clears read/write pointers, `count_o`, `commit_cnt_o`, `overflow_o`, and the post counter. `arm_i` has priority over a simultaneous commit or pop; that commit is neither stored nor counted.
- **RECORD/POST, on each commit:**
  - Store {pc, instr, seq = current `commit_cnt_o`}.
  - Increment `commit_cnt_o` (saturating).
- **Buffer full on a commit:**
  - `mode_i`=0: overwrite the oldest entry, advance the read pointer, set `overflow_o`; count stays at DEPTH.
  - `mode_i`=1: the write never exceeds DEPTH. The commit that makes count = DEPTH moves the block to FROZEN.
- **Trigger (RECORD only):**
  - Fires when `trig_en_i`=1 and `commit_pc_i`==`trig_pc_i`. The matching commit is stored.
  - If `post_trig_i`==0, go to FROZEN; otherwise load `remaining`=`post_trig_i` and go to POST.
- **POST:** each stored commit decrements `remaining`; the commit that makes it 0 moves the block to FROZEN. Full handling is as in RECORD. The mode-1 full rule freezes immediately.
- **FROZEN:**
  - `rd_valid_o` = (`count_o` ≠ 0).
  - On `rd_valid_o` & `rd_ready_i`, pop the oldest entry: read pointer +1 (mod DEPTH), count −1.
  - Commits arriving while FROZEN are dropped and set `overflow_o`; they do not increment `commit_cnt_o`.
  - Stays FROZEN when empty, until `arm_i`.
- **Read port:** `rd_valid_o` is 0 outside FROZEN. The rd_* data fields show the entry at the read pointer, combinationally from the storage registers.

## Timing

- **Reset:** all outputs 0, state IDLE, storage contents don't-care (rd_* data undefined while `rd_valid_o`=0). Takes effect immediately (asynchronous) and overrides any state, including mid-POST or mid-readout.
- **Write latency:** a commit at edge N is reflected in `count_o`, `commit_cnt_o`, `overflow_o` and `state_o` after edge N.
- **Freeze:** the FROZEN transition happens on the same edge as the last stored commit, so `rd_valid_o` is 1 in the next cycle.
- **Reads:** one pop per cycle maximum. rd_* data updates the cycle after a pop.
- **Arm:** `arm_i` takes effect at the edge; RECORD is visible the next cycle.
- **Pointer wrap:** pointers wrap modulo DEPTH without a bubble.

## Test plan

DEPTH=4 in all scenarios.

1. **Reset/IDLE:** assert `rst_i`=0, release, then 3 commits without arm -> all outputs 0, state 0, `commit_cnt_o`=0.
2. **Wrap + trigger, no post:** arm, `mode_i`=0, trigger PC 6, `post_trig_i`=0; commit PCs 1..6 -> FROZEN; count 4; reads return PCs 3,4,5,6 with seq 2,3,4,5; `overflow_o`=1; `commit_cnt_o`=6.
3. **Stop mode:** arm, `mode_i`=1, trigger off; commit PCs 1..6 -> FROZEN after PC 4; reads return PCs 1..4 with seq 0..3; `commit_cnt_o`=4; `overflow_o`=1 (PCs 5 and 6 dropped).
4. **Post-trigger:** arm, `mode_i`=0, trigger PC 8, `post_trig_i`=2; commit PCs 5..11 -> FROZEN after PC 10; reads return 7,8,9,10; `overflow_o`=1.
5. **Backpressure and re-arm:** in FROZEN with 4 entries, toggle `rd_ready_i` 1,0,1 -> exactly 2 pops, data stable while `rd_ready_i`=0. Then `arm_i` together with `rd_ready_i`=1 and a commit -> state RECORD, count 0, `commit_cnt_o`=0.
6. **Reset mid-POST:** drive `rst_i` low mid-POST (`remaining`=1) -> immediate IDLE, all outputs 0. A later arm records from seq 0.
